// File: rtl/y86_status_ctrl.sv
// y86_status_ctrl: architectural status, commit gating and run/stop control
// for the SEQ processor. Holds the datapath frozen once a terminating event
// (HALT, address error, invalid instruction or watchdog timeout) retires.
// Also keeps saturating cycle and instruction counters.
module y86_status_ctrl #(
    parameter int CNT_W       = 32,
    parameter int WDOG_CYCLES = 0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             instr_valid,
    input  logic             imem_error,
    input  logic             instr_invalid,
    input  logic             is_halt,
    input  logic             dmem_error,
    output logic             commit_en,
    output logic             freeze,
    output logic [2:0]       status,
    output logic             done,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic {
        RUN     = 1'b0,
        STOPPED = 1'b1
    } state_t;

    localparam logic [2:0] ST_AOK = 3'd1;
    localparam logic [2:0] ST_HLT = 3'd2;
    localparam logic [2:0] ST_ADR = 3'd3;
    localparam logic [2:0] ST_INS = 3'd4;
    localparam logic [2:0] ST_TMO = 3'd5;

    // The idle counter only has to reach WDOG_CYCLES-1; the timeout fires on
    // the idle cycle that would take it to WDOG_CYCLES.
    localparam int IDLE_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST =
        IDLE_W'((WDOG_CYCLES > 0) ? WDOG_CYCLES - 1 : 0);

    state_t            state;
    logic [IDLE_W-1:0] idle_cnt;
    logic              exc;
    logic              timeout;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Address errors outrank an invalid instruction, which outranks HALT.
    function automatic logic [2:0] exc_code(input logic imem, input logic dmem,
                                            input logic inv);
        if (imem || dmem)
            return ST_ADR;
        else if (inv)
            return ST_INS;
        else
            return ST_HLT;
    endfunction

    assign exc = instr_valid & (imem_error | instr_invalid | is_halt | dmem_error);

    assign timeout = (WDOG_CYCLES > 0) && (state == RUN) && !instr_valid &&
                     (idle_cnt == IDLE_LAST);

    // No architectural writes while in reset, when stopped, or for a
    // faulting/halting instruction.
    assign commit_en = reset_n & (state == RUN) & instr_valid & ~exc;

    // Run/stop state machine with registered status, freeze, done and counters.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= RUN;
            status      <= ST_AOK;
            freeze      <= 1'b0;
            done        <= 1'b0;
            cycle_count <= '0;
            instr_count <= '0;
            idle_cnt    <= '0;
        end else begin
            case (state)
                RUN: begin
                    cycle_count <= sat_inc(cycle_count);
                    if (commit_en)
                        instr_count <= sat_inc(instr_count);
                    done <= 1'b0;
                    if (instr_valid)
                        idle_cnt <= '0;
                    else if (WDOG_CYCLES > 0)
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    if (exc) begin
                        status <= exc_code(imem_error, dmem_error, instr_invalid);
                        state  <= STOPPED;
                        freeze <= 1'b1;
                        done   <= 1'b1;
                    end else if (timeout) begin
                        status <= ST_TMO;
                        state  <= STOPPED;
                        freeze <= 1'b1;
                        done   <= 1'b1;
                    end
                end
                STOPPED: begin
                    done <= 1'b0;
                end
                default: begin
                    state <= STOPPED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_y86_status_ctrl.sv
// Randomized and directed bench for y86_status_ctrl. Two instances share one
// stimulus stream: a (CNT_W=32, no watchdog) and b (CNT_W=4, WDOG_CYCLES=3).
module tb_y86_status_ctrl;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic instr_valid = 1'b0;
    logic imem_error = 1'b0;
    logic instr_invalid = 1'b0;
    logic is_halt = 1'b0;
    logic dmem_error = 1'b0;

    logic        commit_en_a, freeze_a, done_a;
    logic [2:0]  status_a;
    logic [31:0] cycle_count_a, instr_count_a;
    logic        commit_en_b, freeze_b, done_b;
    logic [2:0]  status_b;
    logic [3:0]  cycle_count_b, instr_count_b;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    y86_status_ctrl #(.CNT_W(32), .WDOG_CYCLES(0)) dut_a (
        .clock(clock), .reset_n(reset_n), .instr_valid(instr_valid),
        .imem_error(imem_error), .instr_invalid(instr_invalid),
        .is_halt(is_halt), .dmem_error(dmem_error),
        .commit_en(commit_en_a), .freeze(freeze_a), .status(status_a),
        .done(done_a), .cycle_count(cycle_count_a), .instr_count(instr_count_a)
    );

    y86_status_ctrl #(.CNT_W(4), .WDOG_CYCLES(3)) dut_b (
        .clock(clock), .reset_n(reset_n), .instr_valid(instr_valid),
        .imem_error(imem_error), .instr_invalid(instr_invalid),
        .is_halt(is_halt), .dmem_error(dmem_error),
        .commit_en(commit_en_b), .freeze(freeze_b), .status(status_b),
        .done(done_b), .cycle_count(cycle_count_b), .instr_count(instr_count_b)
    );

    // Reference model: what the processor has observably done so far.
    typedef struct {
        bit     stopped;
        int     status;
        bit     done;
        longint cc;
        longint ic;
        int     idle;
        longint cmax;
        int     wdog;
    } mdl_t;

    mdl_t m [2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit mdl_commit(mdl_t s, bit rst, bit iv, bit im, bit ii, bit ih, bit dm);
        return rst && !s.stopped && iv && !(im || ii || ih || dm);
    endfunction

    function automatic mdl_t mdl_next(mdl_t s, bit rst, bit iv, bit im, bit ii, bit ih, bit dm);
        mdl_t n = s;
        bit fault = iv && (im || ii || ih || dm);
        if (!rst) begin
            n.stopped = 0; n.status = 1; n.done = 0; n.cc = 0; n.ic = 0; n.idle = 0;
        end else if (s.stopped) begin
            n.done = 0;
        end else begin
            n.done = 0;
            n.cc = (s.cc + 1 > s.cmax) ? s.cmax : s.cc + 1;
            if (iv && !fault)
                n.ic = (s.ic + 1 > s.cmax) ? s.cmax : s.ic + 1;
            n.idle = iv ? 0 : s.idle + 1;
            if (fault) begin
                n.status = (im || dm) ? 3 : (ii ? 4 : 2);
                n.stopped = 1;
                n.done = 1;
            end else if (s.wdog > 0 && n.idle >= s.wdog) begin
                n.status = 5;
                n.stopped = 1;
                n.done = 1;
            end
        end
        return n;
    endfunction

    // One clock cycle: drive, check combinational commit, clock, check state.
    task automatic step(input bit rst, input bit iv, input bit im, input bit ii,
                        input bit ih, input bit dm);
        reset_n = rst; instr_valid = iv; imem_error = im;
        instr_invalid = ii; is_halt = ih; dmem_error = dm;
        #3;
        chk("a_commit_en", 64'(commit_en_a), 64'(mdl_commit(m[0], rst, iv, im, ii, ih, dm)));
        chk("b_commit_en", 64'(commit_en_b), 64'(mdl_commit(m[1], rst, iv, im, ii, ih, dm)));
        @(posedge clock);
        m[0] = mdl_next(m[0], rst, iv, im, ii, ih, dm);
        m[1] = mdl_next(m[1], rst, iv, im, ii, ih, dm);
        #1;
        chk("a_status", 64'(status_a), 64'(m[0].status));
        chk("a_freeze", 64'(freeze_a), 64'(m[0].stopped));
        chk("a_done", 64'(done_a), 64'(m[0].done));
        chk("a_cycle_count", 64'(cycle_count_a), 64'(m[0].cc));
        chk("a_instr_count", 64'(instr_count_a), 64'(m[0].ic));
        chk("b_status", 64'(status_b), 64'(m[1].status));
        chk("b_freeze", 64'(freeze_b), 64'(m[1].stopped));
        chk("b_done", 64'(done_b), 64'(m[1].done));
        chk("b_cycle_count", 64'(cycle_count_b), 64'(m[1].cc));
        chk("b_instr_count", 64'(instr_count_b), 64'(m[1].ic));
    endtask

    function automatic bit rb();
        return bit'($urandom % 2);
    endfunction

    initial begin
        m[0] = '{stopped:0, status:1, done:0, cc:0, ic:0, idle:0, cmax:64'hFFFF_FFFF, wdog:0};
        m[1] = '{stopped:0, status:1, done:0, cc:0, ic:0, idle:0, cmax:15, wdog:3};
        @(posedge clock);
        #1;

        // Reset with random flags
        for (int i = 0; i < 2; i++) step(0, rb(), rb(), rb(), rb(), rb());
        chk("t1_status", 64'(status_a), 64'd1);
        chk("t1_freeze", 64'(freeze_a), 64'd0);
        chk("t1_counts", 64'(cycle_count_a) + 64'(instr_count_a), 64'd0);

        // Five clean instructions then HALT
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1, 0);
        chk("t2_status", 64'(status_a), 64'd2);
        chk("t2_done", 64'(done_a), 64'd1);
        chk("t2_instr_count", 64'(instr_count_a), 64'd5);
        chk("t2_cycle_count", 64'(cycle_count_a), 64'd6);
        step(1, 0, 0, 0, 0, 0);
        chk("t2_done_drop", 64'(done_a), 64'd0);

        // Address error outranks invalid and halt; STOPPED ignores inputs
        step(0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 1, 1);
        chk("t3_status", 64'(status_a), 64'd3);
        for (int i = 0; i < 10; i++) step(1, 1, rb(), rb(), rb(), rb());
        chk("t3_status_hold", 64'(status_a), 64'd3);
        chk("t3_cycle_hold", 64'(cycle_count_a), 64'd1);
        chk("t3_instr_hold", 64'(instr_count_a), 64'd0);
        chk("t3_freeze_hold", 64'(freeze_a), 64'd1);

        // Invalid instruction, then a one-cycle reset pulse restarts
        step(0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0, 0);
        chk("t4_status", 64'(status_a), 64'd4);
        step(0, 1, 0, 0, 0, 0);
        chk("t4_status_rst", 64'(status_a), 64'd1);
        chk("t4_cycle_rst", 64'(cycle_count_a), 64'd0);
        step(1, 1, 0, 0, 0, 0);
        chk("t4_instr_commit", 64'(instr_count_a), 64'd1);

        // Watchdog timeout, then an exception on the would-be limit cycle
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, rb(), rb(), rb(), rb());
        chk("t5_tmo", 64'(status_b), 64'd5);
        chk("t5_no_wdog", 64'(status_a), 64'd1);
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 0, 1, 0, 0);
        chk("t5_exc_wins", 64'(status_b), 64'd4);

        // Counter saturation on the narrow instance
        step(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0, 0);
        chk("t6_instr_sat", 64'(instr_count_b), 64'd15);
        chk("t6_cycle_sat", 64'(cycle_count_b), 64'd15);
        chk("t6_status", 64'(status_b), 64'd1);
        chk("t6_wide_count", 64'(instr_count_a), 64'd20);

        // Random traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            step(($urandom % 40) != 0, ($urandom % 4) != 0,
                 ($urandom % 16) == 0, ($urandom % 16) == 0,
                 ($urandom % 16) == 0, ($urandom % 16) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
